i2si_bist_ctrl: RTL
===================

# i2si_bist_ctrl

Sequencing controller for the I2S-input BIST pattern generator (i2si_bist_gen). It captures the register-file BIST configuration into shadow registers and holds the generator in reset until a run starts. It then releases the generator for a programmed number of samples and checks every generated word against an internal model of the expected sequence. During a run it switches the I2S-input data path from live receive data to generator data, and reports busy, done, pass and an error count back to the register file.

## Interface
Parameters:
- DW, 12, sample data width
- CW, 16, sample-count and error-count width

Ports:
- clk  in  1  system clock, single clock domain
- rst  in  1  asynchronous, active-high reset
- rf_bist_start  in  1  one-cycle start pulse
- rf_bist_abort  in  1  level/pulse abort, highest priority after rst
- rf_bist_start_val  in  DW  first pattern value
- rf_bist_inc  in  8  pattern increment
- rf_bist_up_limit  in  DW  pattern wrap limit
- rf_bist_num_samples  in  CW  samples to check per run
- i2si_rx_data  in  DW  live I2S receive word
- i2si_rx_valid  in  1  live word strobe
- i2si_bist_out_data  in  DW  generator output
- bist_gen_rst  out  1  generator reset, active-high
- bist_gen_start_val / bist_gen_inc / bist_gen_up_limit  out  DW/8/DW  shadowed config to generator
- i2si_out_data  out  DW  muxed data to downstream
- i2si_out_valid  out  1  muxed valid
- bist_busy  out  1  run in progress (LOAD/ARM/RUN)
- bist_done  out  1  sticky run-complete flag
- bist_pass  out  1  valid when bist_done=1; 1 = zero mismatches
- bist_err_cnt  out  CW  mismatch count, saturating

## Operation
- FSM states: IDLE, LOAD, ARM, RUN, DONE.
- IDLE: gen_rst=1. rf_bist_start moves the FSM to LOAD.
- LOAD: capture the three config inputs into shadow registers. Set exp=start_val, sample_cnt=0, err_cnt=0, done=0. If num_samples=0, go to DONE with pass=1. Otherwise go to ARM.
- ARM: gen_rst=0 for one cycle with no compare. This lets the registered generator output present start_val in the first RUN cycle. Next state is RUN.
- RUN: gen_rst=0. Each cycle:
  - compare i2si_bist_out_data with exp; on mismatch, err_cnt+1, saturating at 2^CW-1;
  - sample_cnt+1;
  - advance exp.
  - When sample_cnt reaches num_samples-1 in this cycle, go to DONE.
- DONE: gen_rst=1, done=1, pass=(err_cnt==0). Stay until the next start. A start clears done and err_cnt and goes to LOAD.
- Expected-sequence arithmetic: sum = {1'b0,exp} + inc, computed at DW+1 bits. If sum > up_limit, exp_next = start_val; else exp_next = sum[DW-1:0].
  - start_val > up_limit gives a constant start_val sequence.
  - inc=0 gives a constant sequence.
- Generator contract: it outputs start_val in the first RUN cycle and applies the same next-value rule each clock while gen_rst=0.
- Data mux:
  - bist_busy=0: i2si_out_data/valid = i2si_rx_data/valid.
  - RUN: out_data = generator data, out_valid=1.
  - LOAD/ARM: out_valid=0.
- Shadow registers update only in LOAD. RF changes during a run have no effect.
- rf_bist_start in LOAD/ARM/RUN is ignored.
- rf_bist_abort in any state returns the FSM to IDLE next cycle: gen_rst=1, busy=0, done and pass unchanged, err_cnt retains its last value. Abort wins over a simultaneous start.

## Timing
- Reset values (async, on rst=1): state=IDLE, bist_gen_rst=1, shadows=0, i2si_out_data=0, i2si_out_valid=0, bist_busy=0, bist_done=0, bist_pass=0, bist_err_cnt=0.
- All outputs are registered except the data mux, which is combinational from the registered state.
- Start pulse at cycle T:
  - LOAD at T+1, with busy=1 from T+1;
  - ARM at T+2;
  - RUN at T+3 .. T+2+N;
  - DONE at T+3+N, with done/pass valid and busy=0 from T+3+N.
- With N=0: DONE at T+2.
- bist_err_cnt reflects a RUN-cycle mismatch on the following cycle.
- Reset mid-run aborts immediately. There is no resume.

## Test plan
- Nominal run: start_val=0x001, inc=1, limit=0x019, N=30, with a correct generator model. Required response:
  - out_data is 1..25 then 1..5;
  - done at T+33;
  - pass=1, err_cnt=0.
- Fault injection: same configuration, with the bench corrupting the 10th and 20th generator words. Required response: err_cnt=2, pass=0, done at T+33.
- Boundary cases:
  - N=0 gives done at T+2, pass=1 and gen_rst never deasserted.
  - start_val=0x020, limit=0x019, N=4 gives 0x020 four times, pass=1.
  - inc=0xFF, start_val=0xF00, limit=0xFFF checks the 13-bit compare.
- Abort at the 5th RUN cycle, plus a simultaneous start/abort. Required response:
  - IDLE next cycle;
  - gen_rst=1, busy=0, done=0;
  - out_data follows i2si_rx_data again.
- Assert rst asynchronously mid-RUN. Required response: all outputs at reset values in the same cycle. A subsequent start runs a clean N=30 pass.
- Change RF config during RUN and send a start pulse during RUN. Required response: the run completes with the original config and the start is ignored.

Source files
------------

// File: rtl/i2si_bist_ctrl.sv
// rtl/i2si_bist_ctrl.sv - sequencing and checking controller for the I2S-input BIST generator
// Shadows the RF BIST config, runs the generator for N samples and scores each word against a model.
module i2si_bist_ctrl #(
   parameter int DW = 12,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          rf_bist_start,
   input  logic          rf_bist_abort,
   input  logic [DW-1:0] rf_bist_start_val,
   input  logic [7:0]    rf_bist_inc,
   input  logic [DW-1:0] rf_bist_up_limit,
   input  logic [CW-1:0] rf_bist_num_samples,
   input  logic [DW-1:0] i2si_rx_data,
   input  logic          i2si_rx_valid,
   input  logic [DW-1:0] i2si_bist_out_data,
   output logic          bist_gen_rst,
   output logic [DW-1:0] bist_gen_start_val,
   output logic [7:0]    bist_gen_inc,
   output logic [DW-1:0] bist_gen_up_limit,
   output logic [DW-1:0] i2si_out_data,
   output logic          i2si_out_valid,
   output logic          bist_busy,
   output logic          bist_done,
   output logic          bist_pass,
   output logic [CW-1:0] bist_err_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ARM,
      S_RUN,
      S_DONE
   } state_t;

   state_t          state_q;
   state_t          state_d;
   logic [DW-1:0]   exp_q;
   logic [CW-1:0]   cnt_q;
   logic [CW-1:0]   num_q;
   logic [DW:0]     sum;
   logic [DW-1:0]   exp_adv;
   logic [CW-1:0]   err_nxt;
   logic            last_sample;

   // One extra bit so a wrap past the top of the DW range still compares above the limit
   always_comb begin
      sum         = {1'b0, exp_q} + {{(DW-7){1'b0}}, bist_gen_inc};
      exp_adv     = (sum > {1'b0, bist_gen_up_limit}) ? bist_gen_start_val : sum[DW-1:0];
      err_nxt     = bist_err_cnt;
      if ((i2si_bist_out_data != exp_q) && (bist_err_cnt != '1)) begin
         err_nxt = bist_err_cnt + CW'(1);
      end
      last_sample = (cnt_q == (num_q - CW'(1)));
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE: if (rf_bist_start) state_d = S_LOAD;
         S_LOAD:         state_d = (rf_bist_num_samples == '0) ? S_DONE : S_ARM;
         S_ARM:          state_d = S_RUN;
         S_RUN:          if (last_sample) state_d = S_DONE;
         default:        state_d = S_IDLE;
      endcase
      if (rf_bist_abort) state_d = S_IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q            <= S_IDLE;
         bist_gen_rst       <= 1'b1;
         bist_busy          <= 1'b0;
         bist_done          <= 1'b0;
         bist_pass          <= 1'b0;
         bist_err_cnt       <= '0;
         bist_gen_start_val <= '0;
         bist_gen_inc       <= '0;
         bist_gen_up_limit  <= '0;
         num_q              <= '0;
         exp_q              <= '0;
         cnt_q              <= '0;
      end else begin
         state_q      <= state_d;
         bist_gen_rst <= !((state_d == S_ARM) || (state_d == S_RUN));
         bist_busy    <= (state_d == S_LOAD) || (state_d == S_ARM) || (state_d == S_RUN);
         // Abort freezes the status flags and the error count exactly as they are
         if (!rf_bist_abort) begin
            case (state_q)
               S_IDLE, S_DONE: begin
                  if (rf_bist_start) begin
                     bist_done    <= 1'b0;
                     bist_pass    <= 1'b0;
                     bist_err_cnt <= '0;
                  end
               end
               S_LOAD: begin
                  bist_gen_start_val <= rf_bist_start_val;
                  bist_gen_inc       <= rf_bist_inc;
                  bist_gen_up_limit  <= rf_bist_up_limit;
                  num_q              <= rf_bist_num_samples;
                  exp_q              <= rf_bist_start_val;
                  cnt_q              <= '0;
                  bist_err_cnt       <= '0;
                  if (rf_bist_num_samples == '0) begin
                     bist_done <= 1'b1;
                     bist_pass <= 1'b1;
                  end
               end
               S_RUN: begin
                  bist_err_cnt <= err_nxt;
                  cnt_q        <= cnt_q + CW'(1);
                  exp_q        <= exp_adv;
                  if (last_sample) begin
                     bist_done <= 1'b1;
                     bist_pass <= (err_nxt == '0);
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Live data passes through whenever no run is active; held at zero while in reset
   always_comb begin
      i2si_out_data  = '0;
      i2si_out_valid = 1'b0;
      if (!rst) begin
         if (state_q == S_RUN) begin
            i2si_out_data  = i2si_bist_out_data;
            i2si_out_valid = 1'b1;
         end else if ((state_q == S_IDLE) || (state_q == S_DONE)) begin
            i2si_out_data  = i2si_rx_data;
            i2si_out_valid = i2si_rx_valid;
         end
      end
   end

endmodule
